// File: rtl/dmem_lsu_master_pkg.sv
// dmem_lsu_master_pkg: shared funct3 codes, FSM states and lane size helpers for the LSU
package dmem_lsu_master_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} state_e;
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;
  function automatic logic [63:0] size_mask(input logic [1:0] sz);
    return sz == SZ_B ? 64'h0000_0000_0000_00FF :
           sz == SZ_H ? 64'h0000_0000_0000_FFFF :
           sz == SZ_W ? 64'h0000_0000_FFFF_FFFF : '1;
  endfunction
endpackage

// File: rtl/dmem_lsu_master_if.sv
// dmem_lsu_master_if: core request/response handshake plus dmem bus seen by the LSU
interface dmem_lsu_master_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic        resp_err;
  logic        mem_we;
  logic [63:0] mem_a;
  logic [63:0] mem_wd;
  logic [63:0] mem_rd;
  modport master (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready, mem_rd,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_we, mem_a, mem_wd
  );
  modport slave (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready, mem_rd,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_we, mem_a, mem_wd
  );
endinterface

// File: rtl/dmem_lsu_master_lane_align.sv
// lsu_lane_align: little-endian lane extraction/extension, store merge and alignment check
module lsu_lane_align
  import dmem_lsu_master_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [2:0]  off,
  input  logic [63:0] rd,
  input  logic [63:0] wdata,
  output logic [63:0] load_ext,
  output logic [63:0] store_merged,
  output logic        misaligned
);
  logic [1:0]  sz;
  logic [5:0]  sh;
  logic [63:0] mask;
  logic [63:0] lane;
  assign sz   = funct3[1:0];
  assign sh   = {off, 3'b000};
  assign mask = size_mask(sz);
  assign lane = rd >> sh;
  assign load_ext = funct3[2]  ? lane & mask :
                    sz == SZ_B ? {{56{lane[7]}}, lane[7:0]} :
                    sz == SZ_H ? {{48{lane[15]}}, lane[15:0]} :
                    sz == SZ_W ? {{32{lane[31]}}, lane[31:0]} : lane;
  assign store_merged = (rd & ~(mask << sh)) | ((wdata & mask) << sh);
  assign misaligned = sz == SZ_H ? off[0] :
                      sz == SZ_W ? |off[1:0] :
                      sz == SZ_D ? |off : 1'b0;
endmodule

// File: rtl/dmem_lsu_master.sv
// dmem_lsu_master: valid/ready load/store unit driving a doubleword dmem with RMW sub-word stores
module dmem_lsu_master
  import dmem_lsu_master_pkg::*;
#(
  parameter int MEM_WORDS = 256
) (
  input logic              clk,
  input logic              reset_n,
  dmem_lsu_master_if.master bus
);
  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  f3_q, f3_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [63:0] buf_q, buf_d;
  logic [63:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        idle;
  logic [2:0]  f3_sel;
  logic [2:0]  off_sel;
  logic [63:0] rd_sel;
  logic [63:0] load_ext;
  logic [63:0] store_merged;
  logic        misaligned;
  logic        req_err;
  assign idle    = state_q == IDLE;
  // In IDLE the aligner checks the incoming request; afterwards it works on the latched one.
  assign f3_sel  = idle ? bus.req_funct3 : f3_q;
  assign off_sel = idle ? bus.req_addr[2:0] : addr_q[2:0];
  assign rd_sel  = state_q == WRITE ? buf_q : bus.mem_rd;
  lsu_lane_align u_align (
    .funct3      (f3_sel),
    .off         (off_sel),
    .rd          (rd_sel),
    .wdata       (wdata_q),
    .load_ext    (load_ext),
    .store_merged(store_merged),
    .misaligned  (misaligned)
  );
  assign req_err = misaligned || bus.req_funct3 == 3'b111 || (bus.req_we && bus.req_funct3[2])
                   || bus.req_addr[63:3] >= 61'(MEM_WORDS);
  assign bus.req_ready  = idle;
  assign bus.resp_valid = state_q == RESP;
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;
  // Write strobe is purely state-decoded so an asynchronous reset removes it immediately.
  assign bus.mem_we = (state_q == ACCESS && we_q && f3_q[1:0] == SZ_D) || state_q == WRITE;
  assign bus.mem_a  = {addr_q[63:3], 3'b000};
  assign bus.mem_wd = state_q == WRITE ? store_merged : wdata_q;
  // Next-state and latch logic for accept, access, read-modify-write and response hold.
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    buf_d   = buf_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (bus.req_valid) begin
        we_d    = bus.req_we;
        f3_d    = bus.req_funct3;
        addr_d  = bus.req_addr;
        wdata_d = bus.req_wdata;
        rdata_d = '0;
        err_d   = req_err;
        state_d = req_err ? RESP : ACCESS;
      end
      ACCESS: begin
        rdata_d = we_q ? '0 : load_ext;
        buf_d   = bus.mem_rd;
        state_d = (we_q && f3_q[1:0] != SZ_D) ? WRITE : RESP;
      end
      WRITE:   state_d = RESP;
      RESP:    state_d = bus.resp_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  // State and request latches with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      buf_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      buf_q   <= buf_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end
endmodule
